// File: rtl/voice_mixer_pwm.sv
// voice_mixer_pwm: four-voice envelope mixer feeding a 256-step PWM audio output.
// Each voice sample is centred, scaled by its decaying 4-bit envelope, summed over two
// register stages into an unsigned 8-bit mix level, and that level sets the PWM duty
// once per 256-clock period.
module voice_mixer_pwm #(
   parameter logic [11:0] ENV_DIV = 12'd4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sample1,
   input  logic [7:0]  sample2,
   input  logic [7:0]  sample3,
   input  logic [7:0]  sample4,
   input  logic [3:0]  note_on,
   input  logic [3:0]  voice_en,
   output logic        pwm_out,
   output logic [7:0]  mix_level,
   output logic [15:0] env_levels,
   output logic        period_start
);

   localparam int unsigned NumVoices = 4;

   // Envelope prescaler
   logic [11:0] presc_q;
   logic [11:0] presc_d;
   logic        env_tick;

   // Envelope levels
   logic [3:0] env_q [NumVoices];
   logic [3:0] env_d [NumVoices];

   // Stage 1: per-voice scaled contribution
   logic [7:0]         sample    [NumVoices];
   logic [7:0]         centered  [NumVoices];
   logic signed [11:0] product   [NumVoices];
   logic signed [7:0]  scaled_d  [NumVoices];
   logic signed [7:0]  scaled_q  [NumVoices];

   // Stage 2: mix
   logic signed [9:0] sum;
   logic [7:0]        mix_d;

   // PWM
   logic [7:0] cnt_q;
   logic [7:0] duty_q;
   logic       pwm_d;
   logic       period_start_d;

   // Fraction bits dropped by the >>4 and >>2 scaling; read here so they are not dangling.
   logic unused_frac;

   // Gather the four sample ports into an indexable array.
   always_comb begin
      sample[0] = sample1;
      sample[1] = sample2;
      sample[2] = sample3;
      sample[3] = sample4;
   end

   // Prescaler: count down, reload and tick when it reaches zero.
   always_comb begin
      env_tick = (presc_q == 12'd0);
      presc_d  = env_tick ? ENV_DIV : presc_q - 12'd1;
   end

   // Envelope next state: retrigger beats a simultaneous decay tick; decay saturates at 0.
   always_comb begin
      for (int i = 0; i < NumVoices; i++) begin
         env_d[i] = env_q[i];
         if (note_on[i]) begin
            env_d[i] = 4'd15;
         end else if (env_tick && (env_q[i] != 4'd0)) begin
            env_d[i] = env_q[i] - 4'd1;
         end
      end
   end

   // Prescaler and envelope state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= 12'd0;
         for (int i = 0; i < NumVoices; i++) begin
            env_q[i] <= 4'd0;
         end
      end else begin
         presc_q <= presc_d;
         for (int i = 0; i < NumVoices; i++) begin
            env_q[i] <= env_d[i];
         end
      end
   end

   // Stage 1 datapath: centre sample, multiply by current level, floor-divide by 16.
   always_comb begin
      for (int i = 0; i < NumVoices; i++) begin
         // Offset-binary to two's complement: 128 becomes 0.
         centered[i] = {~sample[i][7], sample[i][6:0]};
         // |s * level| <= 1920 fits a 12-bit signed product.
         product[i]  = $signed({{4{centered[i][7]}}, centered[i]}) *
                       $signed({8'd0, env_q[i]});
         // Taking bits [11:4] of a two's-complement value is a flooring shift by 4.
         scaled_d[i] = voice_en[i] ? product[i][11:4] : 8'sd0;
      end
   end

   // Stage 1 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumVoices; i++) begin
            scaled_q[i] <= 8'sd0;
         end
      end else begin
         for (int i = 0; i < NumVoices; i++) begin
            scaled_q[i] <= scaled_d[i];
         end
      end
   end

   // Stage 2 datapath: sum four voices and bias into unsigned 8-bit range.
   always_comb begin
      sum = {{2{scaled_q[0][7]}}, scaled_q[0]} +
            {{2{scaled_q[1][7]}}, scaled_q[1]} +
            {{2{scaled_q[2][7]}}, scaled_q[2]} +
            {{2{scaled_q[3][7]}}, scaled_q[3]};
      // sum lies in -480..476, so adding 512 never carries out of 10 bits and is just an
      // MSB flip; the >>2 then keeps bits [9:2].
      mix_d = {~sum[9], sum[8:2]};
   end

   always_comb begin
      unused_frac = ^{sum[1:0], product[0][3:0], product[1][3:0],
                      product[2][3:0], product[3][3:0]};
   end

   // Stage 2 register: mix level output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_level <= 8'd128;
      end else begin
         mix_level <= mix_d;
      end
   end

   // PWM compare and period marker, both registered one clock after the counter.
   always_comb begin
      pwm_d          = (cnt_q < duty_q);
      period_start_d = (cnt_q == 8'hFF);
   end

   // PWM counter, duty latch (only at period end) and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= 8'd0;
         duty_q       <= 8'd128;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         cnt_q        <= cnt_q + 8'd1;
         pwm_out      <= pwm_d;
         period_start <= period_start_d;
         if (cnt_q == 8'hFF) begin
            duty_q <= mix_level;
         end
      end
   end

   assign env_levels = {env_q[3], env_q[2], env_q[1], env_q[0]};

endmodule
